bsg_manycore_link_to_axil_rd_ctrl: RTL and testbench
====================================================

# bsg_manycore_link_to_axil_rd_ctrl

AXI-Lite read-channel controller for the manycore-to-host receive path. It decodes host reads and serves each one from one of four sources: the request-word stream, the response-word stream, their occupancy counters, or a sticky error counter. A data read pops exactly one word from the selected stream. The block sits between the host AXI-Lite slave port and the rx request/response buffers, so the host can poll occupancy and drain packets word by word.

## Interface
Parameters:
- axil_data_width_p, 32, AXI-Lite data width; must equal the stream word width.
- axil_addr_width_p, 32, AXI-Lite address width.
- count_width_p, 8, occupancy counter width; must be ≤ axil_data_width_p.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset. One clock; reset is synchronous and active-high.
- axil_araddr_i  in  axil_addr_width_p  read address.
- axil_arvalid_i  in  1  AR valid.
- axil_arready_o  out  1  AR ready.
- axil_rdata_o  out  axil_data_width_p  read data.
- axil_rresp_o  out  2  2'b00 OKAY, 2'b10 SLVERR.
- axil_rvalid_o  out  1  R valid.
- axil_rready_i  in  1  R ready.
- req_data_i  in  axil_data_width_p  head word of the request stream.
- req_v_i  in  1  request head valid.
- req_yumi_o  out  1  request pop.
- req_count_i  in  count_width_p  request buffer occupancy.
- rsp_data_i, rsp_v_i, rsp_yumi_o, rsp_count_i: same as the req_* ports, for the response stream.

## Operation
Address map: decode araddr[7:0]; all higher bits are ignored.
- 0x00: pop a request word.
- 0x04: request occupancy.
- 0x08: pop a response word.
- 0x0C: response occupancy.
- 0x10: error count. Reading it clears the count.

State machine:
- IDLE: arready=1. On arvalid&arready (the AR handshake), decode the address, latch rdata/rresp, and go to RESP.
- RESP: rvalid=1, arready=0. Hold rdata/rresp stable until rvalid&rready, then return to IDLE.

Read rules:
- Data read with the stream's v_i=1: assert the matching yumi_o for exactly the AR handshake cycle. Latch data_i. rresp=OKAY.
- Data read with v_i=0: no pop. rdata=0, rresp=SLVERR, error count +1.
- Occupancy read: count_i sampled in the AR handshake cycle, zero-extended. rresp=OKAY.
- Error-count read: rdata = current count, zero-extended. Count clears to 0 in the same cycle. rresp=OKAY.
- Unaligned address (araddr[1:0]≠0) or unmapped offset: rdata=0, rresp=SLVERR, error count +1, no pop.

Error count:
- 8-bit, saturates at 255.
- If an increment and a clear fall in the same cycle, the clear wins. This cannot happen with a single outstanding read, but the RTL must encode the priority.

At most one yumi_o is asserted in any cycle.

## Timing
- Reset values: arready=0 while reset_i=1. rvalid=0, rdata=0, rresp=0, req/rsp yumi=0, error count=0, state=IDLE.
- Latency: rvalid rises the cycle after the AR handshake.
- Minimum spacing: 2 cycles per read when rready is held high. No AR is accepted in the cycle rvalid&rready completes.
- rdata/rresp change only on an AR handshake.
- yumi_o is combinational from arvalid, state, decode and v_i. It never depends on rready.
- Reset during RESP: the R beat is dropped. The word was already popped at AR and is lost. This is the documented behaviour.
- Backpressure: with rready=0 indefinitely, the block stays in RESP with stable outputs, and further ARs are stalled.

## Structure
- Address offsets (0x00–0x10), rresp encodings and the error-counter width are constants in bsg_manycore_link_to_axil_pkg. The state enum is also defined there.
- No sub-module is required. The saturating error counter is inline logic.
- The block instantiates alongside the rx buffers: req_* connects to the request rx path outputs, and req_count_i connects to its credit/occupancy count.

## Test plan
- req_v_i=1 with req_data_i=0xDEADBEEF; read 0x00 with rready=1 → req_yumi_o for one cycle; R is rdata=0xDEADBEEF, rresp=00 one cycle after AR; next AR is accepted 2 cycles after the first.
- rsp_v_i=0; read 0x08 → no rsp_yumi_o, rdata=0, rresp=10. Then read 0x10 → rdata=1. Read 0x10 again → rdata=0.
- req_count_i=5, rsp_count_i=0x80; read 0x04 and 0x0C → 0x00000005 and 0x00000080, OKAY, no pops.
- Read 0x02 (unaligned) and 0x20 (unmapped) → SLVERR both. Then 300 erroring reads, then read 0x10 → rdata=255.
- Read 0x00 with rready=0 for 10 cycles → rvalid high and rdata stable throughout, arready=0, only one pop total. Then rready=1 → handshake, back to IDLE.
- Assert reset_i during RESP → next cycle rvalid=0, arready=0. After reset release, arready=1 and the error count is 0.

Source files
------------

// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// Shared constants for the manycore-link AXI-Lite host read path:
// register offsets, response codes, error-counter sizing and the read FSM states.
package bsg_manycore_link_to_axil_pkg;

    localparam logic [7:0] OFF_REQ_DATA  = 8'h00;
    localparam logic [7:0] OFF_REQ_COUNT = 8'h04;
    localparam logic [7:0] OFF_RSP_DATA  = 8'h08;
    localparam logic [7:0] OFF_RSP_COUNT = 8'h0C;
    localparam logic [7:0] OFF_ERR_COUNT = 8'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_ONE = 1;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } rd_state_e;

endpackage

// File: rtl/bsg_manycore_link_to_axil_rd_ctrl_if.sv
// AXI-Lite read address / read data channels between the host and the read controller.
interface bsg_manycore_link_to_axil_rd_ctrl_if #(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32
);
    logic [axil_addr_width_p-1:0] araddr;
    logic                         arvalid;
    logic                         arready;
    logic [axil_data_width_p-1:0] rdata;
    logic [1:0]                   rresp;
    logic                         rvalid;
    logic                         rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/bsg_manycore_link_to_axil_rd_ctrl.sv
// Host read controller: serves each AXI-Lite read from the request/response word
// streams, their occupancy counts, or a read-to-clear saturating error counter.
module bsg_manycore_link_to_axil_rd_ctrl
    import bsg_manycore_link_to_axil_pkg::*;
#(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32,
    parameter int count_width_p     = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,

    bsg_manycore_link_to_axil_rd_ctrl_if.slave axil,

    input  logic [axil_data_width_p-1:0] req_data_i,
    input  logic                         req_v_i,
    output logic                         req_yumi_o,
    input  logic [count_width_p-1:0]     req_count_i,

    input  logic [axil_data_width_p-1:0] rsp_data_i,
    input  logic                         rsp_v_i,
    output logic                         rsp_yumi_o,
    input  logic [count_width_p-1:0]     rsp_count_i
);

    rd_state_e                    state_reg, state_next;
    logic [axil_data_width_p-1:0] rdata_reg, rdata_next;
    logic [1:0]                   rresp_reg, rresp_next;
    logic [ERR_CNT_W-1:0]         err_cnt_reg, err_cnt_next;
    logic                         err_inc, err_clr;
    logic                         arready;
    logic [7:0]                   offset;
    logic                         unused_addr_bits;

    assign offset           = axil.araddr[7:0];
    assign unused_addr_bits = ^axil.araddr[axil_addr_width_p-1:8];

    always_comb begin
        state_next = state_reg;
        rdata_next = rdata_reg;
        rresp_next = rresp_reg;
        arready    = 1'b0;
        req_yumi_o = 1'b0;
        rsp_yumi_o = 1'b0;
        err_inc    = 1'b0;
        err_clr    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Gating with reset keeps arready and both pops low while reset is held.
                arready = ~reset_i;
                if (axil.arvalid && arready) begin
                    state_next = ST_RESP;
                    rdata_next = '0;
                    rresp_next = RESP_OKAY;
                    if (offset[1:0] != 2'b00) begin
                        rresp_next = RESP_SLVERR;
                        err_inc    = 1'b1;
                    end else begin
                        case (offset)
                            OFF_REQ_DATA: begin
                                if (req_v_i) begin
                                    req_yumi_o = 1'b1;
                                    rdata_next = req_data_i;
                                end else begin
                                    rresp_next = RESP_SLVERR;
                                    err_inc    = 1'b1;
                                end
                            end
                            OFF_RSP_DATA: begin
                                if (rsp_v_i) begin
                                    rsp_yumi_o = 1'b1;
                                    rdata_next = rsp_data_i;
                                end else begin
                                    rresp_next = RESP_SLVERR;
                                    err_inc    = 1'b1;
                                end
                            end
                            OFF_REQ_COUNT: rdata_next[count_width_p-1:0] = req_count_i;
                            OFF_RSP_COUNT: rdata_next[count_width_p-1:0] = rsp_count_i;
                            OFF_ERR_COUNT: begin
                                rdata_next[ERR_CNT_W-1:0] = err_cnt_reg;
                                err_clr                   = 1'b1;
                            end
                            default: begin
                                rresp_next = RESP_SLVERR;
                                err_inc    = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_RESP: begin
                if (axil.rready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Clear takes priority over a simultaneous increment; increment saturates.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (err_clr) begin
            err_cnt_next = '0;
        end else if (err_inc && (err_cnt_reg != ERR_CNT_MAX)) begin
            err_cnt_next = err_cnt_reg + ERR_CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg   <= ST_IDLE;
            rdata_reg   <= '0;
            rresp_reg   <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rdata_reg   <= rdata_next;
            rresp_reg   <= rresp_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign axil.arready = arready;
    assign axil.rvalid  = (state_reg == ST_RESP);
    assign axil.rdata   = rdata_reg;
    assign axil.rresp   = rresp_reg;

endmodule

// File: tb/tb_bsg_manycore_link_to_axil_rd_ctrl.sv
// Bench for the manycore-link AXI-Lite read controller: directed vector table,
// hand-written multi-cycle sequences, and randomized reads against a reference model.
module tb_bsg_manycore_link_to_axil_rd_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] req_data = '0, rsp_data = '0;
    logic        req_v = 1'b0, rsp_v = 1'b0;
    logic        req_yumi, rsp_yumi;
    logic [7:0]  req_count = '0, rsp_count = '0;

    int checks = 0;
    int errors = 0;
    int req_pops = 0;
    int rsp_pops = 0;
    int cyc = 0;
    int hs_n = 0;
    int hs_last = 0;
    int hs_prev = 0;
    int m_err = 0;

    bsg_manycore_link_to_axil_rd_ctrl_if #(.axil_data_width_p(32), .axil_addr_width_p(32)) axil ();

    bsg_manycore_link_to_axil_rd_ctrl #(
        .axil_data_width_p(32),
        .axil_addr_width_p(32),
        .count_width_p(8)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .axil(axil),
        .req_data_i(req_data),
        .req_v_i(req_v),
        .req_yumi_o(req_yumi),
        .req_count_i(req_count),
        .rsp_data_i(rsp_data),
        .rsp_v_i(rsp_v),
        .rsp_yumi_o(rsp_yumi),
        .rsp_count_i(rsp_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (req_yumi) req_pops++;
        if (rsp_yumi) rsp_pops++;
        if (axil.arvalid && axil.arready) begin
            hs_prev = hs_last;
            hs_last = cyc;
            hs_n++;
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        rq_v;
        logic [31:0] rq_d;
        logic        rs_v;
        logic [31:0] rs_d;
        logic [7:0]  rq_c;
        logic [7:0]  rs_c;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        int          exp_rq_pop;
        int          exp_rs_pop;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: what one host read should return, from the address map and read rules.
    task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r,
                              output int rq_pop, output int rs_pop);
        int off;
        bit bad;
        off = int'(addr % 256);
        d = 0; r = 2'b00; rq_pop = 0; rs_pop = 0; bad = 0;
        if (off % 4 != 0) bad = 1;
        else if (off == 0) begin
            if (req_v) begin d = req_data; rq_pop = 1; end else bad = 1;
        end else if (off == 8) begin
            if (rsp_v) begin d = rsp_data; rs_pop = 1; end else bad = 1;
        end else if (off == 4) d = 32'(req_count);
        else if (off == 12) d = 32'(rsp_count);
        else if (off == 16) begin d = 32'(m_err); m_err = 0; end
        else bad = 1;
        if (bad) begin
            d = 0; r = 2'b10;
            m_err = (m_err >= 255) ? 255 : m_err + 1;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int stall, input bit hold_ar,
                           input logic [31:0] exp_d, input logic [1:0] exp_r,
                           input int exp_rq_pop, input int exp_rs_pop, input string name);
        int n;
        int rq0;
        int rs0;
        rq0 = req_pops;
        rs0 = rsp_pops;
        @(negedge clk);
        axil.araddr  = addr;
        axil.arvalid = 1'b1;
        axil.rready  = (stall == 0);
        n = 0;
        while (!axil.arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!axil.arready) begin
            chk({name, " ar_timeout"}, 32'(axil.arready), 32'd1);
            axil.arvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold_ar) axil.arvalid = 1'b0;
        chk({name, " rvalid"}, 32'(axil.rvalid), 32'd1);
        chk({name, " rdata"}, axil.rdata, exp_d);
        chk({name, " rresp"}, 32'(axil.rresp), 32'(exp_r));
        $display("read %s addr=%h rdata=%h rresp=%0d stall=%0d", name, addr, axil.rdata, axil.rresp, stall);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({name, " hold"}, {axil.rvalid, axil.arready, axil.rresp, axil.rdata[27:0]},
                {1'b1, 1'b0, exp_r, exp_d[27:0]});
            if (i == stall - 1) axil.rready = 1'b1;
        end
        @(posedge clk);
        #1;
        axil.arvalid = 1'b0;
        axil.rready  = 1'b0;
        chk({name, " rvalid_done"}, 32'(axil.rvalid), 32'd0);
        chk({name, " req_pops"}, 32'(req_pops - rq0), 32'(exp_rq_pop));
        chk({name, " rsp_pops"}, 32'(rsp_pops - rs0), 32'(exp_rs_pop));
    endtask

    initial begin
        logic [31:0] ed;
        logic [1:0]  er;
        int          ep_rq;
        int          ep_rs;
        logic [31:0] a;

        axil.araddr  = '0;
        axil.arvalid = 1'b0;
        axil.rready  = 1'b0;

        // Reset state, with a pending data read that must not pop.
        req_v = 1'b1; req_data = 32'hCAFE0001;
        axil.arvalid = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset arready", 32'(axil.arready), 32'd0);
        chk("reset rvalid", 32'(axil.rvalid), 32'd0);
        chk("reset rdata", axil.rdata, 32'd0);
        chk("reset rresp", 32'(axil.rresp), 32'd0);
        chk("reset pops", 32'(req_pops + rsp_pops), 32'd0);
        axil.arvalid = 1'b0;
        reset = 1'b0;
        #1;
        chk("post-reset arready", 32'(axil.arready), 32'd1);

        vecs[0]  = '{32'h00, 1, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00, 1, 0};
        vecs[1]  = '{32'h08, 0, 0, 0, 0, 0, 0, 32'h0, 2'b10, 0, 0};
        vecs[2]  = '{32'h10, 0, 0, 0, 0, 0, 0, 32'h1, 2'b00, 0, 0};
        vecs[3]  = '{32'h10, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 0};
        vecs[4]  = '{32'h04, 1, 32'h1111, 1, 32'h2222, 8'd5, 8'h80, 32'h5, 2'b00, 0, 0};
        vecs[5]  = '{32'h0C, 1, 32'h1111, 1, 32'h2222, 8'd5, 8'h80, 32'h80, 2'b00, 0, 0};
        vecs[6]  = '{32'h02, 1, 32'h1111, 1, 32'h2222, 0, 0, 32'h0, 2'b10, 0, 0};
        vecs[7]  = '{32'h20, 1, 32'h1111, 1, 32'h2222, 0, 0, 32'h0, 2'b10, 0, 0};
        vecs[8]  = '{32'hFFFFFF08, 1, 32'h1111, 1, 32'h12345678, 0, 0, 32'h12345678, 2'b00, 0, 1};
        vecs[9]  = '{32'h10, 0, 0, 0, 0, 0, 0, 32'h2, 2'b00, 0, 0};
        vecs[10] = '{32'h0D, 1, 32'h1111, 1, 32'h2222, 0, 0, 32'h0, 2'b10, 0, 0};
        vecs[11] = '{32'h14, 1, 32'h1111, 1, 32'h2222, 0, 0, 32'h0, 2'b10, 0, 0};
        vecs[12] = '{32'h10, 0, 0, 0, 0, 0, 0, 32'h2, 2'b00, 0, 0};

        for (int i = 0; i < 13; i++) begin
            req_v = vecs[i].rq_v; req_data = vecs[i].rq_d;
            rsp_v = vecs[i].rs_v; rsp_data = vecs[i].rs_d;
            req_count = vecs[i].rq_c; rsp_count = vecs[i].rs_c;
            do_read(vecs[i].addr, 0, 0, vecs[i].exp_d, vecs[i].exp_r,
                    vecs[i].exp_rq_pop, vecs[i].exp_rs_pop, $sformatf("vec%0d", i));
        end
        m_err = 0;

        // Back-to-back reads with arvalid held: one accept every 2 cycles.
        req_count = 8'd9;
        @(negedge clk);
        axil.araddr = 32'h04; axil.arvalid = 1'b1; axil.rready = 1'b1;
        hs_n = 0;
        repeat (6) @(negedge clk);
        axil.arvalid = 1'b0; axil.rready = 1'b0;
        chk("spacing count", 32'(hs_n), 32'd3);
        chk("spacing gap", 32'(hs_last - hs_prev), 32'd2);
        $display("read spacing addr=04 handshakes=%0d gap=%0d", hs_n, hs_last - hs_prev);

        // Saturation of the error counter.
        req_v = 1'b0; rsp_v = 1'b0;
        for (int i = 0; i < 300; i++) begin
            a = (i % 3 == 0) ? 32'h00 : (i % 3 == 1) ? 32'h08 : 32'h41;
            do_read(a, 0, 0, 32'h0, 2'b10, 0, 0, "err");
        end
        do_read(32'h10, 0, 0, 32'd255, 2'b00, 0, 0, "sat");
        do_read(32'h10, 0, 0, 32'd0, 2'b00, 0, 0, "sat_clr");

        // Backpressure: 10 stalled cycles with AR held, exactly one pop.
        req_v = 1'b1; req_data = 32'hA5A55A5A;
        do_read(32'h00, 10, 1, 32'hA5A55A5A, 2'b00, 1, 0, "bp");
        #1;
        chk("bp back to idle", 32'(axil.arready), 32'd1);

        // Reset during RESP drops the beat and clears the error count.
        do_read(32'h30, 0, 0, 32'h0, 2'b10, 0, 0, "pre_rst_err");
        ep_rq = req_pops;
        @(negedge clk);
        axil.araddr = 32'h00; axil.arvalid = 1'b1; axil.rready = 1'b0;
        @(posedge clk);
        #1;
        axil.arvalid = 1'b0;
        chk("rst rvalid before", 32'(axil.rvalid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst rvalid", 32'(axil.rvalid), 32'd0);
        chk("rst arready", 32'(axil.arready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst release arready", 32'(axil.arready), 32'd1);
        chk("rst pops", 32'(req_pops - ep_rq), 32'd1);
        $display("read reset_in_resp addr=00 pops=%0d", req_pops - ep_rq);
        do_read(32'h10, 0, 0, 32'd0, 2'b00, 0, 0, "rst_errcnt");

        // Randomized reads against the reference model.
        m_err = 0;
        for (int i = 0; i < 200; i++) begin
            int sel;
            sel = $urandom_range(0, 6);
            case (sel)
                0: a = 32'h00;
                1: a = 32'h04;
                2: a = 32'h08;
                3: a = 32'h0C;
                4: a = 32'h10;
                5: a = $urandom;
                default: a = {$urandom_range(0, 63), 2'b00} | 32'(1 + $urandom_range(0, 2));
            endcase
            if (sel < 5) a = a | {$urandom, 8'h00};
            req_v = 1'($urandom); rsp_v = 1'($urandom);
            req_data = $urandom; rsp_data = $urandom;
            req_count = 8'($urandom); rsp_count = 8'($urandom);
            model_read(a, ed, er, ep_rq, ep_rs);
            do_read(a, $urandom_range(0, 3), 1'($urandom), ed, er, ep_rq, ep_rs, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
